mtime_responder: RTL and testbench
==================================

// Module: mtime_responder
// PURPOSE
// Memory-mapped RISC-V machine timer: bus responder (the memory-side end) of the core's mem_rd_en/mem_wr_en/busy handshake.
// Sits behind memory_controller alongside ROM/RAM, selected by its own chip_select.
// Holds a 64-bit mtime counter and a 64-bit mtimecmp register; raises timer_irq when mtime >= mtimecmp.
// PARAMETERS
// ADDR_SIZE  12  address bits decoded; timer map lives at offsets 0x0..0xF
// DATA_SIZE  64  data width; fixed, only 64 supported
// BUSY_TIME  12  cycles busy stays high per access; legal range >= 1
// PRESCALE   1   clock cycles per mtime increment; legal range >= 1
// PORTS
// clock          in   1          system clock, rising edge
// reset          in   1          asynchronous, active-high
// address        in   ADDR_SIZE  byte address; [3] selects register, [2:0] ignored
// write_data     in   64         write data, byte lanes gated by byte_enable
// output_enable  in   1          read request
// write_enable   in   1          write request
// chip_select    in   1          block selected by memory_controller
// byte_enable    in   8          lane i enables bits [8i+7:8i]
// read_data      out  64         read result, valid from the cycle busy falls
// busy           out  1          access in progress
// timer_irq      out  1          registered (mtime >= mtimecmp), unsigned compare
// BEHAVIOUR
// - Reset (async): FSM=IDLE, busy=0, read_data=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, timer_irq=0, prescaler=0.
// - Map: 0x0 mtime, 0x8 mtimecmp. address[ADDR_SIZE-1:4] != 0 -> read returns 0, write discarded; handshake still completes.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: at rising edge with chip_select & (output_enable | write_enable), latch address, write_data, byte_enable, op; go BUSY.
//   BUSY: busy=1 for exactly BUSY_TIME cycles (counter). At the final edge: capture read_data / commit write; go DONE.
//   DONE: busy=0, read_data held; requests ignored this cycle (the initiator drops its enable combinationally on busy fall); go IDLE.
// - Latency: request sampled at edge N -> busy high N+1..N+BUSY_TIME -> busy low and data valid after edge N+BUSY_TIME.
// - Reads: read_data = full 64-bit register value with bytes where byte_enable=0 forced to 0; held until the next read completes.
// - Writes: only enabled lanes updated; others keep current value.
// - output_enable and write_enable both high: treated as write; read_data returns pre-write value, masked.
// - mtime: prescaler counts 0..PRESCALE-1; mtime += 1 when it wraps; 2^64-1 wraps to 0.
// - Write to mtime on the same edge as an increment: write wins on enabled lanes; disabled lanes take the incremented value.
// - timer_irq: one-cycle lag after mtime/mtimecmp change; level, cleared only by raising mtimecmp or writing mtime.
// - chip_select/enables dropping mid-BUSY: access completes from latched values.
// - Reset mid-access: abort, no write committed, busy=0 immediately.
// - read_data is not cleared by writes or by non-selected cycles.
// STRUCTURE
// - Shared constants in the core defines package/header: MTIME_OFFSET=4'h0, MTIMECMP_OFFSET=4'h8.
// - One sub-module: mtime_prescaler (free-running mod-PRESCALE counter, 1-cycle tick output).
// - Access FSM and registers in this module.
// TESTING
// 1. Reset -> busy=0, read_data=0, timer_irq=0; read 0x8 with be=8'hFF -> 64'hFFFF_FFFF_FFFF_FFFF.
// 2. PRESCALE=1, read 0x0 issued at cycle 100 after reset -> busy high exactly BUSY_TIME=12 cycles; data within 1 of the cycle count at capture.
// 3. Write 0x8 = 64'h0000_0000_0000_0040, be=8'h0F -> upper bytes keep FFFF_FFFF; read back 64'hFFFF_FFFF_0000_0040.
// 4. mtimecmp=64'd50, mtime counting -> timer_irq rises the cycle after mtime reaches 50; write mtimecmp=64'd1000 -> irq falls one cycle later.
// 5. Write mtime=64'hFFFF_FFFF_FFFF_FFFE -> after 2 ticks reads 0 (wrap); read to 0x10 -> 0, busy still pulses 12 cycles.
// 6. Assert reset at BUSY cycle 5 of write 0x8 = 64'd7 -> busy=0 at once; mtimecmp reads all-ones afterwards.

Source files
------------

// File: rtl/mtime_responder_pkg.sv
// Shared definitions for the memory-mapped machine timer.
//   - register offsets inside the 16-byte timer window
//   - access FSM state encoding
//   - byte-lane helpers used for masked reads and partial writes
package mtime_responder_pkg;

  localparam logic [3:0] MTIME_OFFSET    = 4'h0;
  localparam logic [3:0] MTIMECMP_OFFSET = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Expand an 8-bit lane enable into a 64-bit bit mask.
  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Replace the enabled lanes of cur with the matching lanes of nxt.
  function automatic logic [63:0] be_merge(input logic [63:0] cur,
                                           input logic [63:0] nxt,
                                           input logic [7:0]  be);
    logic [63:0] m;
    m = be_mask(be);
    return (nxt & m) | (cur & ~m);
  endfunction

endpackage

// File: rtl/mtime_responder_if.sv
// Bus between memory_controller (master) and the timer responder (slave).
//   address/write_data/byte_enable : access target and payload
//   output_enable/write_enable     : read / write request
//   chip_select                    : this responder selected
//   read_data/busy                 : response from the responder
interface mtime_responder_if #(
  parameter int ADDR_SIZE = 12
) ();
  logic [ADDR_SIZE-1:0] address;
  logic [63:0]          write_data;
  logic                 output_enable;
  logic                 write_enable;
  logic                 chip_select;
  logic [7:0]           byte_enable;
  logic [63:0]          read_data;
  logic                 busy;

  modport master (
    output address, write_data, output_enable, write_enable, chip_select, byte_enable,
    input  read_data, busy
  );

  modport slave (
    input  address, write_data, output_enable, write_enable, chip_select, byte_enable,
    output read_data, busy
  );
endinterface

// File: rtl/mtime_prescaler.sv
// Free-running modulo-PRESCALE counter that pulses tick for one cycle on
// the final count, which is the cycle mtime advances.
//   clock, reset : clock and asynchronous active-high reset
//   tick         : high during the last cycle of each PRESCALE period
module mtime_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          wrap_s;

  assign wrap_s = (cnt_q == CNT_LAST);
  assign tick   = wrap_s;

  // Next count: wrap to zero after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_s) begin
      cnt_d = {PW{1'b0}};
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mtime_responder.sv
// RISC-V machine timer behind the memory controller.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : slave side of the mem handshake (read/write, busy)
//   timer_irq    : registered mtime >= mtimecmp (unsigned)
// Map: offset 0x0 mtime, 0x8 mtimecmp; any address with bits above [3]
// set reads 0 and drops writes, but still runs the full busy handshake.
module mtime_responder
  import mtime_responder_pkg::*;
#(
  parameter int ADDR_SIZE = 12,
  parameter int DATA_SIZE = 64,
  parameter int BUSY_TIME = 12,
  parameter int PRESCALE  = 1
) (
  input  logic                clock,
  input  logic                reset,
  mtime_responder_if.slave    bus,
  output logic                timer_irq
);
  localparam int CW = (BUSY_TIME > 1) ? $clog2(BUSY_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIME - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_SIZE-1:3]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
  logic [7:0]             be_q, be_d;
  logic                   rd_op_q, rd_op_d;
  logic                   wr_op_q, wr_op_d;
  logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic [DATA_SIZE-1:0]   mtime_q, mtime_d;
  logic [DATA_SIZE-1:0]   mtimecmp_q, mtimecmp_d;
  logic                   irq_q, irq_d;

  logic                   tick_s;
  logic                   in_range_s;
  logic                   sel_mtime_s;
  logic                   sel_cmp_s;
  logic [DATA_SIZE-1:0]   mtime_inc_s;
  logic [DATA_SIZE-1:0]   cur_s;
  logic                   unused_addr_bits_s;

  mtime_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  // Byte offset within a register is irrelevant; only [3] picks the register.
  assign unused_addr_bits_s = ^bus.address[2:0];

  assign in_range_s  = (addr_q[ADDR_SIZE-1:4] == {(ADDR_SIZE-4){1'b0}});
  assign sel_mtime_s = ({addr_q[3], 3'b000} == MTIME_OFFSET);
  assign sel_cmp_s   = ({addr_q[3], 3'b000} == MTIMECMP_OFFSET);

  assign bus.read_data = rdata_q;
  assign bus.busy      = busy_q;
  assign timer_irq     = irq_q;

  // Addressed register value and the free-running increment of mtime.
  always_comb begin
    mtime_inc_s = mtime_q;
    cur_s       = {DATA_SIZE{1'b0}};
    if (tick_s) begin
      mtime_inc_s = mtime_q + 64'd1;
    end else begin
      mtime_inc_s = mtime_q;
    end
    if (!in_range_s) begin
      cur_s = {DATA_SIZE{1'b0}};
    end else if (sel_cmp_s) begin
      cur_s = mtimecmp_q;
    end else if (sel_mtime_s) begin
      cur_s = mtime_q;
    end else begin
      cur_s = {DATA_SIZE{1'b0}};
    end
  end

  // Access FSM, read capture and register update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_op_d    = rd_op_q;
    wr_op_d    = wr_op_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    mtime_d    = mtime_inc_s;
    mtimecmp_d = mtimecmp_q;
    // The compare sees the registered values, giving the one-cycle lag.
    irq_d      = (mtime_q >= mtimecmp_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.chip_select && (bus.output_enable || bus.write_enable)) begin
          addr_d  = bus.address[ADDR_SIZE-1:3];
          wdata_d = bus.write_data;
          be_d    = bus.byte_enable;
          rd_op_d = bus.output_enable;
          wr_op_d = bus.write_enable;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
          // A combined read+write still returns the pre-write value.
          if (rd_op_q) begin
            rdata_d = cur_s & be_mask(be_q);
          end else begin
            rdata_d = rdata_q;
          end
          if (wr_op_q && in_range_s && sel_cmp_s) begin
            mtimecmp_d = be_merge(mtimecmp_q, wdata_q, be_q);
          end else if (wr_op_q && in_range_s && sel_mtime_s) begin
            // Disabled lanes keep the incremented value of this edge.
            mtime_d = be_merge(mtime_inc_s, wdata_q, be_q);
          end else begin
            mtimecmp_d = mtimecmp_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      addr_q     <= {(ADDR_SIZE-3){1'b0}};
      wdata_q    <= {DATA_SIZE{1'b0}};
      be_q       <= 8'h00;
      rd_op_q    <= 1'b0;
      wr_op_q    <= 1'b0;
      rdata_q    <= {DATA_SIZE{1'b0}};
      busy_q     <= 1'b0;
      mtime_q    <= {DATA_SIZE{1'b0}};
      mtimecmp_q <= {DATA_SIZE{1'b1}};
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_op_q    <= rd_op_d;
      wr_op_q    <= wr_op_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end
endmodule

// File: tb/tb_mtime_responder.sv
// Self-checking bench for mtime_responder (PRESCALE=1, BUSY_TIME=12).
// Expected results are computed from a small timer model when a request is
// accepted, pushed to a scoreboard, and compared when busy falls.
module tb_mtime_responder;
  localparam int ADDR_SIZE = 12;
  localparam int BUSY_TIME = 12;

  logic clock;
  logic reset;
  logic timer_irq;

  mtime_responder_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  mtime_responder #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (64),
    .BUSY_TIME (BUSY_TIME),
    .PRESCALE  (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; with PRESCALE=1 mtime tracks this exactly.
  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks;
  int errors;

  // Timer model.
  logic [63:0] m_cmp;
  logic [63:0] mt_base;
  int          mt_base_cyc;
  logic [63:0] last_rd;

  typedef struct {
    logic [63:0] data;
    int          cap;
  } exp_t;
  exp_t sb[$];

  // mtime value held after clock edge k.
  function automatic logic [63:0] mtime_at(input int k);
    return mt_base + 64'(k - mt_base_cyc);
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  be);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;
    mt_base     = 64'd0;
    mt_base_cyc = 0;
    last_rd     = 64'd0;
    sb.delete();
  endtask

  task automatic idle_bus();
    bus.address       = 12'h000;
    bus.write_data    = 64'd0;
    bus.output_enable = 1'b0;
    bus.write_enable  = 1'b0;
    bus.chip_select   = 1'b0;
    bus.byte_enable   = 8'h00;
  endtask

  // One complete access: wait for acceptance, predict, then wait for busy fall.
  task automatic access(input string name, input logic oe, input logic we,
                        input logic [11:0] addr, input logic [63:0] wd,
                        input logic [7:0] be);
    logic        accepted;
    logic        fell;
    logic        in_range;
    logic [63:0] cur;
    logic [63:0] m;
    int          bcount;
    exp_t        e;
    bus.address       = addr;
    bus.write_data    = wd;
    bus.byte_enable   = be;
    bus.output_enable = oe;
    bus.write_enable  = we;
    bus.chip_select   = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 4 && !accepted; i++) begin
      @(posedge clock); #1;
      if (bus.busy === 1'b1) accepted = 1'b1;
    end
    idle_bus();
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL %s accept: busy never rose, required 1", name);
      return;
    end
    // Prediction at acceptance: capture happens BUSY_TIME edges later.
    e.cap    = cyc + BUSY_TIME;
    in_range = (addr[11:4] == 8'h00);
    cur      = !in_range ? 64'd0 : (addr[3] ? m_cmp : mtime_at(e.cap - 1));
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
    e.data   = oe ? (cur & m) : last_rd;
    last_rd  = e.data;
    sb.push_back(e);
    if (we && in_range) begin
      if (addr[3]) begin
        m_cmp = lane_merge(m_cmp, wd, be);
      end else begin
        mt_base     = lane_merge(mtime_at(e.cap - 1) + 64'd1, wd, be);
        mt_base_cyc = e.cap;
      end
    end
    bcount = 1;
    fell   = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(posedge clock); #1;
      if (bus.busy === 1'b0) fell = 1'b1;
      else                   bcount++;
    end
    e = sb.pop_front();
    checks++;
    if (!fell || bcount != BUSY_TIME) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d fell=%b, required %0d", name, bcount, fell, BUSY_TIME);
    end
    checks++;
    if (cyc != e.cap) begin
      errors++;
      $display("FAIL %s capture_cycle: got %0d, required %0d", name, cyc, e.cap);
    end
    checks++;
    if (bus.read_data !== e.data) begin
      errors++;
      $display("FAIL %s read_data: got %h, required %h", name, bus.read_data, e.data);
    end
  endtask

  task automatic apply_reset();
    idle_bus();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++;
    if (bus.read_data !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", bus.read_data); end
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", timer_irq); end
    @(negedge clock);
    reset = 1'b0;
    access("rd_cmp_reset", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
  endtask

  task automatic test_mtime_read();
    for (int i = 0; i < 200 && cyc < 99; i++) @(posedge clock);
    #1;
    access("rd_mtime_c100", 1'b1, 1'b0, 12'h000, 64'd0, 8'hFF);
    access("rd_mtime_be3c", 1'b1, 1'b0, 12'h004, 64'd0, 8'h3C);
  endtask

  task automatic test_partial_write();
    access("wr_cmp_lo", 1'b0, 1'b1, 12'h008, 64'h0000_0000_0000_0040, 8'h0F);
    access("rd_cmp_full", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
    access("rd_cmp_hi", 1'b1, 1'b0, 12'h00C, 64'd0, 8'hF0);
  endtask

  task automatic test_irq();
    int rise;
    int exp_rise;
    access("wr_mtime_0", 1'b0, 1'b1, 12'h000, 64'd0, 8'hFF);
    access("wr_cmp_50", 1'b0, 1'b1, 12'h008, 64'd50, 8'hFF);
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b, required 0", timer_irq); end
    exp_rise = mt_base_cyc + int'(64'd50 - mt_base) + 1;
    rise = -1;
    for (int i = 0; i < 300 && rise < 0; i++) begin
      @(posedge clock); #1;
      if (timer_irq === 1'b1) rise = cyc;
    end
    checks++;
    if (rise != exp_rise) begin errors++; $display("FAIL irq_rise_cycle: got %0d, required %0d", rise, exp_rise); end
    access("wr_cmp_1000", 1'b0, 1'b1, 12'h008, 64'd1000, 8'hFF);
    checks++;
    if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b, required 1", timer_irq); end
    @(posedge clock); #1;
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b, required 0", timer_irq); end
  endtask

  task automatic test_wrap_and_range();
    access("wr_mtime_max", 1'b0, 1'b1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    access("rd_mtime_wrap", 1'b1, 1'b0, 12'h000, 64'd0, 8'hFF);
    access("rd_out_of_range", 1'b1, 1'b0, 12'h010, 64'd0, 8'hFF);
    access("wr_out_of_range", 1'b0, 1'b1, 12'h018, 64'd0, 8'hFF);
    access("rd_cmp_kept", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
    access("rdwr_cmp", 1'b1, 1'b1, 12'h008, 64'h0000_0000_0000_1234, 8'h03);
    access("rd_cmp_after_rdwr", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
  endtask

  task automatic test_back_to_back();
    access("b2b_rd_mtime", 1'b1, 1'b0, 12'h000, 64'd0, 8'hFF);
    access("b2b_rd_cmp", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
    access("b2b_wr_cmp", 1'b0, 1'b1, 12'h008, 64'hAAAA_5555_0000_0000, 8'hC0);
    access("b2b_rd_cmp2", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
  endtask

  task automatic test_reset_mid_access();
    logic accepted;
    bus.address       = 12'h008;
    bus.write_data    = 64'd7;
    bus.byte_enable   = 8'hFF;
    bus.write_enable  = 1'b1;
    bus.output_enable = 1'b0;
    bus.chip_select   = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 4 && !accepted; i++) begin
      @(posedge clock); #1;
      if (bus.busy === 1'b1) accepted = 1'b1;
    end
    idle_bus();
    checks++;
    if (!accepted) begin errors++; $display("FAIL midrst_accept: busy never rose, required 1"); end
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    access("rd_cmp_after_midrst", 1'b1, 1'b0, 12'h008, 64'd0, 8'hFF);
    checks++;
    if (bus.read_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL midrst_cmp_const: got %h, required ffffffffffffffff", bus.read_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_bus();
    model_reset();
    test_reset();
    test_mtime_read();
    test_partial_write();
    test_irq();
    test_wrap_and_range();
    test_back_to_back();
    test_reset_mid_access();
    apply_reset();
    access("rd_mtime_final", 1'b1, 1'b0, 12'h000, 64'd0, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
